// File: rtl/multiword_cu_if.sv
// Decode-stage <-> multi-word sequencer bundle.
// master: decode/memory side driving the instruction and back-pressure.
// slave : the sequencer producing beat offsets and PC/stall control.
interface multiword_cu_if #(
   parameter int OP_W  = 6,
   parameter int RD_W  = 4,
   parameter int OFF_W = 2
);
   logic             valid;
   logic [OP_W-1:0]  op_code;
   logic [RD_W-1:0]  rd;
   logic             mem_ready;
   logic             flush;
   logic             mem_en;
   logic [OFF_W-1:0] rd_off;
   logic [OFF_W-1:0] imm_off;
   logic             add_rd;
   logic             add_imm;
   logic             add_pc;
   logic             last_beat;
   logic             turn_off;
   logic             busy;

   modport master (
      output valid, op_code, rd, mem_ready, flush,
      input  mem_en, rd_off, imm_off, add_rd, add_imm, add_pc, last_beat, turn_off, busy
   );

   modport slave (
      input  valid, op_code, rd, mem_ready, flush,
      output mem_en, rd_off, imm_off, add_rd, add_imm, add_pc, last_beat, turn_off, busy
   );
endinterface

// File: rtl/multiword_cu.sv
// Multi-word load/store beat sequencer for the decode stage.
// Holds a double/quad-word instruction in decode while its beats issue,
// supplying per-beat register and immediate word offsets.
// Optional: MULTIWORD_CU_QUAD_EN enables 4-beat quad-word opcodes; without it
// quad opcodes decode as ordinary single-beat instructions.
module multiword_cu #(
   parameter int OP_W          = 6,
   parameter int RD_W          = 4,
   parameter int CMP_W         = 4,
   parameter int DBL_CODE      = 8,
   parameter int DBL_CODE_ALT  = 9,
   parameter int QUAD_CODE     = 10,
   parameter int QUAD_CODE_ALT = 11,
   parameter int OFF_W         = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   multiword_cu_if.slave   bus
);
   // nbeats must hold the value 4, one bit wider than the beat index
   localparam int NB_W = OFF_W + 1;
   localparam logic [CMP_W-1:0] DBL_C   = CMP_W'(DBL_CODE);
   localparam logic [CMP_W-1:0] DBL_A_C = CMP_W'(DBL_CODE_ALT);
   localparam logic [CMP_W-1:0] QUD_C   = CMP_W'(QUAD_CODE);
   localparam logic [CMP_W-1:0] QUD_A_C = CMP_W'(QUAD_CODE_ALT);
`ifdef MULTIWORD_CU_QUAD_EN
   localparam logic QUAD_EN = 1'b1;
`else
   localparam logic QUAD_EN = 1'b0;
`endif

   typedef enum logic {IDLE, SEQ} state_t;

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [NB_W-1:0]   nbeats_q, nbeats_d;

   logic [CMP_W-1:0]  opc;
   logic              is_dbl, is_quad, aligned, seq_last;
   logic [NB_W-1:0]   n_dec;

   logic              mem_en, add_rd, add_imm, add_pc, last_beat, turn_off, busy;
   logic [OFF_W-1:0]  rd_off, imm_off;

   assign opc = bus.op_code[CMP_W-1:0];

   // Classify the opcode into 1/2/4 beats and check base-register alignment
   always_comb begin
      is_dbl  = (opc == DBL_C) || (opc == DBL_A_C);
      is_quad = QUAD_EN && ((opc == QUD_C) || (opc == QUD_A_C));
      n_dec   = is_quad ? NB_W'(4) : (is_dbl ? NB_W'(2) : NB_W'(1));
      aligned = is_quad ? (bus.rd[1:0] == 2'b00) : (is_dbl ? !bus.rd[0] : 1'b1);
   end

   // The latched beat count, not the (held) opcode, defines the final beat
   assign seq_last = ({1'b0, cnt_q} == (nbeats_q - NB_W'(1)));

   // Next-state and beat outputs; flush overrides everything including mem_ready
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nbeats_d  = nbeats_q;
      mem_en    = 1'b0;
      rd_off    = '0;
      imm_off   = '0;
      add_rd    = 1'b0;
      add_imm   = 1'b0;
      add_pc    = 1'b0;
      last_beat = 1'b0;
      turn_off  = 1'b0;
      busy      = 1'b0;
      if (bus.flush) begin
         add_pc  = 1'b1;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.valid) begin
                  add_pc = 1'b1;
               end else if (n_dec == NB_W'(1)) begin
                  mem_en    = 1'b1;
                  last_beat = 1'b1;
                  add_pc    = bus.mem_ready;
               end else if (!aligned) begin
                  turn_off = 1'b1;
                  add_pc   = 1'b1;
               end else begin
                  // beat 0 re-presents until memory takes it
                  mem_en = 1'b1;
                  if (bus.mem_ready) begin
                     nbeats_d = n_dec;
                     cnt_d    = OFF_W'(1);
                     state_d  = SEQ;
                  end
               end
            end
            SEQ: begin
               busy      = 1'b1;
               mem_en    = 1'b1;
               rd_off    = cnt_q;
               imm_off   = cnt_q;
               add_rd    = 1'b1;
               add_imm   = 1'b1;
               last_beat = seq_last;
               add_pc    = seq_last && bus.mem_ready;
               if (bus.mem_ready) begin
                  if (seq_last) begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + OFF_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Sequencer state; reset abandons any partial instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         nbeats_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         nbeats_q <= nbeats_d;
      end
   end

   assign bus.mem_en    = mem_en;
   assign bus.rd_off    = rd_off;
   assign bus.imm_off   = imm_off;
   assign bus.add_rd    = add_rd;
   assign bus.add_imm   = add_imm;
   assign bus.add_pc    = add_pc;
   assign bus.last_beat = last_beat;
   assign bus.turn_off  = turn_off;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_multiword_cu.sv
// Testbench for multiword_cu: table of single-cycle IDLE vectors, hand-written
// multi-cycle sequences, then randomized traffic against a beat-queue model.
module tb_multiword_cu;
`ifdef MULTIWORD_CU_QUAD_EN
   localparam bit QUAD = 1'b1;
`else
   localparam bit QUAD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   q[$];   // beat offsets still owed by the instruction in progress

   multiword_cu_if #(.OP_W(6), .RD_W(4), .OFF_W(2)) bus ();

   multiword_cu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        v;
      logic [5:0]  op;
      logic [3:0]  rd;
      logic        mr;
      logic        fl;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[10];

   // {mem_en, rd_off, imm_off, add_rd, add_imm, add_pc, last_beat, turn_off, busy}
   function automatic logic [10:0] pk(logic me, logic [1:0] ro, logic [1:0] io, logic ar,
                                      logic ai, logic ap, logic lb, logic to, logic bz);
      return {me, ro, io, ar, ai, ap, lb, to, bz};
   endfunction

   function automatic logic [10:0] idle_o();
      return pk(0, 0, 0, 0, 0, 1, 0, 0, 0);
   endfunction

   function automatic int n_of(logic [5:0] op);
      case (op[3:0])
         4'd8, 4'd9:   return 2;
         4'd10, 4'd11: return QUAD ? 4 : 1;
         default:      return 1;
      endcase
   endfunction

   function automatic logic [10:0] model_exp();
      int  n;
      int  c;
      logic last;
      if (bus.flush) return idle_o();
      if (q.size() > 0) begin
         c    = q[0];
         last = (q.size() == 1);
         return pk(1, 2'(c), 2'(c), 1, 1, last & bus.mem_ready, last, 0, 1);
      end
      if (!bus.valid) return idle_o();
      n = n_of(bus.op_code);
      if (n == 1) return pk(1, 0, 0, 0, 0, bus.mem_ready, 1, 0, 0);
      if ((int'(bus.rd) % n) != 0) return pk(0, 0, 0, 0, 0, 1, 0, 1, 0);
      return pk(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic model_upd();
      int n;
      if (bus.flush) begin
         q.delete();
      end else if (q.size() > 0) begin
         if (bus.mem_ready) void'(q.pop_front());
      end else if (bus.valid && bus.mem_ready) begin
         n = n_of(bus.op_code);
         if (n > 1 && (int'(bus.rd) % n) == 0)
            for (int b = 1; b < n; b++) q.push_back(b);
      end
   endtask

   task automatic drive(logic v, logic [5:0] op, logic [3:0] rd, logic mr, logic fl);
      bus.valid     = v;
      bus.op_code   = op;
      bus.rd        = rd;
      bus.mem_ready = mr;
      bus.flush     = fl;
   endtask

   task automatic chk(string name, logic [10:0] exp);
      logic [10:0] act;
      act = {bus.mem_en, bus.rd_off, bus.imm_off, bus.add_rd, bus.add_imm,
             bus.add_pc, bus.last_beat, bus.turn_off, bus.busy};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (me,ro,io,ar,ai,ap,lb,to,bz) t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_upd();
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{"idle_nv",    0, 6'b000000, 4'd0, 1, 0, pk(0,0,0,0,0,1,0,0,0)};
      tbl[1] = '{"single_rdy", 1, 6'b000001, 4'd0, 1, 0, pk(1,0,0,0,0,1,1,0,0)};
      tbl[2] = '{"single_stl", 1, 6'b000001, 4'd0, 0, 0, pk(1,0,0,0,0,0,1,0,0)};
      tbl[3] = '{"dbl_misal",  1, 6'b001001, 4'd3, 1, 0, pk(0,0,0,0,0,1,0,1,0)};
      tbl[4] = '{"dbl_b0_stl", 1, 6'b001000, 4'd2, 0, 0, pk(1,0,0,0,0,0,0,0,0)};
      tbl[5] = '{"hi_ignored", 1, 6'b111000, 4'd1, 1, 0, pk(0,0,0,0,0,1,0,1,0)};
      tbl[6] = '{"flush_idle", 1, 6'b001000, 4'd0, 1, 1, pk(0,0,0,0,0,1,0,0,0)};
      tbl[7] = '{"single_odd", 1, 6'b000111, 4'd5, 0, 0, pk(1,0,0,0,0,0,1,0,0)};
`ifdef MULTIWORD_CU_QUAD_EN
      tbl[8] = '{"quad_misal", 1, 6'b001011, 4'd1, 1, 0, pk(0,0,0,0,0,1,0,1,0)};
      tbl[9] = '{"quad_mis2",  1, 6'b001010, 4'd2, 0, 0, pk(0,0,0,0,0,1,0,1,0)};
`else
      tbl[8] = '{"quad_single", 1, 6'b001011, 4'd1, 1, 0, pk(1,0,0,0,0,1,1,0,0)};
      tbl[9] = '{"quad_sgl_st", 1, 6'b001010, 4'd2, 0, 0, pk(1,0,0,0,0,0,1,0,0)};
`endif

      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk("reset", idle_o());
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();

      // single-cycle vectors, none of which leave IDLE
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].mr, tbl[i].fl);
         #1 chk(tbl[i].name, tbl[i].exp);
         tick();
      end

      // double-word, no stall
      drive(1, 6'b001000, 4'd2, 1, 0);
      #1 chk("dbl_b0", pk(1,0,0,0,0,0,0,0,0));
      tick();
      #1 chk("dbl_b1", pk(1,1,1,1,1,1,1,0,1));
      tick();
      drive(0, 0, 0, 1, 0);
      #1 chk("dbl_done", idle_o());
      tick();

      // misaligned double squashes without entering the sequence
      drive(1, 6'b001001, 4'd3, 1, 0);
      #1 chk("mis_sq", pk(0,0,0,0,0,1,0,1,0));
      tick();
      drive(0, 0, 0, 1, 0);
      #1 chk("mis_noseq", idle_o());
      tick();

`ifdef MULTIWORD_CU_QUAD_EN
      // quad with a stall on beat 2: beats 0,1,2,2,3
      drive(1, 6'b001010, 4'd4, 1, 0);
      #1 chk("q_b0", pk(1,0,0,0,0,0,0,0,0));
      tick();
      #1 chk("q_b1", pk(1,1,1,1,1,0,0,0,1));
      tick();
      bus.mem_ready = 0;
      #1 chk("q_b2_stall", pk(1,2,2,1,1,0,0,0,1));
      tick();
      bus.mem_ready = 1;
      #1 chk("q_b2", pk(1,2,2,1,1,0,0,0,1));
      tick();
      #1 chk("q_b3", pk(1,3,3,1,1,1,1,0,1));
      tick();
      drive(0, 0, 0, 1, 0);
      #1 chk("q_done", idle_o());
      tick();
      // flush at beat 2
      drive(1, 6'b001011, 4'd8, 1, 0);
      tick();
      tick();
      bus.flush = 1;
      #1 chk("q_flush", idle_o());
      tick();
      drive(0, 0, 0, 1, 0);
      #1 chk("q_post_fl", idle_o());
      tick();
`else
      // double with a stall on beat 1
      drive(1, 6'b001000, 4'd0, 1, 0);
      #1 chk("d_b0", pk(1,0,0,0,0,0,0,0,0));
      tick();
      bus.mem_ready = 0;
      #1 chk("d_b1_stall", pk(1,1,1,1,1,0,1,0,1));
      tick();
      bus.mem_ready = 1;
      #1 chk("d_b1", pk(1,1,1,1,1,1,1,0,1));
      tick();
      drive(0, 0, 0, 1, 0);
      #1 chk("d_done", idle_o());
      tick();
      // flush on beat 1
      drive(1, 6'b001001, 4'd6, 1, 0);
      tick();
      bus.flush = 1;
      #1 chk("d_flush", idle_o());
      tick();
      drive(0, 0, 0, 1, 0);
      #1 chk("d_post_fl", idle_o());
      tick();
`endif

      // reset mid-sequence
      drive(1, 6'b001000, 4'd4, 1, 0);
      tick();
      #1 chk("rst_pre", pk(1,1,1,1,1,1,1,0,1));
      bus.mem_ready = 0;
      rst_n = 1'b0;
      #1 chk("rst_mid", pk(1,0,0,0,0,0,0,0,0));
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 1, 0);
      #1 chk("rst_after", idle_o());
      tick();

      // randomized traffic against the beat-queue model
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] lo;
         lo = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(8, 11)) : 4'($urandom);
         drive($urandom_range(0, 3) != 0, {2'($urandom), lo}, 4'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
         #1 chk("rand", model_exp());
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multiword_cu.md
Name: multiword_cu

Overview:
- Parametrised multi-word access sequencer for the decode stage of the pipelined CPU.
- Detects double-word (2-beat) and quad-word (4-beat) load/store opcodes and holds the instruction in decode while the beats issue.
- For each beat it supplies the register offset and immediate word offset, and stalls on memory back-pressure.
- Misaligned destination registers squash the instruction with a fault flag.

Parameters:
- OP_W, 6, opcode width
- RD_W, 4, register index width
- CMP_W, 4, number of low opcode bits compared; upper opcode bits are ignored
- DBL_CODE, 8, first double-word opcode (low CMP_W bits)
- DBL_CODE_ALT, 9, second double-word opcode
- QUAD_CODE, 10, first quad-word opcode
- QUAD_CODE_ALT, 11, second quad-word opcode
- OFF_W, 2, width of beat/offset outputs; must be >= 2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  decode holds a valid instruction
- op_code  in  OP_W  instruction opcode
- rd  in  RD_W  base destination/source register
- mem_ready  in  1  memory accepts the current beat this cycle
- flush  in  1  pipeline flush (branch/exception)
- mem_en  out  1  a beat is being presented to memory this cycle
- rd_off  out  OFF_W  beat index, added to rd by the register file path
- imm_off  out  OFF_W  word offset, added to the immediate (scaled x4 downstream)
- add_rd  out  1  rd_off != 0
- add_imm  out  1  imm_off != 0
- add_pc  out  1  PC may advance / decode may accept the next instruction
- last_beat  out  1  current beat is the final one
- turn_off  out  1  misaligned multi-word instruction squashed
- busy  out  1  sequencer is in a multi-beat instruction past beat 0

Behaviour:
- Decode classes: N=2 for DBL_CODE/DBL_CODE_ALT, N=4 for QUAD_CODE/QUAD_CODE_ALT, else N=1. All compares use op_code[CMP_W-1:0].
- Alignment: N=2 requires rd[0]=0; N=4 requires rd[1:0]=0.
- State registers:
  - state in {IDLE, SEQ}
  - cnt (OFF_W bits)
  - nbeats (latched N)
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, nbeats=0.
  - Outputs are combinational from state/inputs. With valid=0 after reset: add_pc=1, all other outputs 0.
- IDLE, valid=0: add_pc=1, mem_en=0, all other outputs 0.
- IDLE, valid=1, N=1:
  - mem_en=1, rd_off=0, last_beat=1, add_pc=mem_ready.
  - Stays in IDLE.
- IDLE, valid=1, N>1, misaligned:
  - turn_off=1, mem_en=0, add_pc=1.
  - No beats issue; stays in IDLE.
- IDLE, valid=1, N>1, aligned:
  - Beat 0 issues: mem_en=1, rd_off=imm_off=0, add_pc=0.
  - If mem_ready: latch nbeats=N, cnt<=1, go to SEQ. Otherwise stay in IDLE and re-present beat 0.
- SEQ:
  - busy=1, mem_en=1, rd_off=imm_off=cnt, add_rd=add_imm=1, last_beat=(cnt==nbeats-1).
  - add_pc = last_beat & mem_ready.
  - mem_ready=0: hold cnt, all outputs stable.
  - mem_ready=1 and not last beat: cnt<=cnt+1.
  - mem_ready=1 and last beat: cnt<=0, state<=IDLE.
- In SEQ, op_code/rd/valid are ignored. Decode holds the instruction because add_pc=0, and nbeats is authoritative.
- flush=1, any state:
  - Outputs forced to the IDLE/valid=0 values that cycle (mem_en=0, add_pc=1, turn_off=0).
  - Next edge: state=IDLE, cnt=0.
  - flush takes priority over mem_ready.
- Reset asserted mid-sequence: immediate return to IDLE/cnt=0; the partial instruction is abandoned.
- cnt never wraps: the maximum value is 3, reached only when N=4.

Optional Feature:
- Macro: MULTIWORD_CU_QUAD_EN.
- Defined: quad-word opcodes behave as above (4 beats, 4-aligned rd).
- Undefined:
  - QUAD_CODE/QUAD_CODE_ALT decode as N=1 (single beat, no alignment check).
  - The sequencer handles only N=2, so cnt never exceeds 1.
  - QUAD_CODE and QUAD_CODE_ALT still elaborate but are unused.

Test Plan:
- Reset then op_code=6'b000001, rd=0, valid=1, mem_ready=1 -> mem_en=1, last_beat=1, add_pc=1, rd_off=0 every cycle, busy=0.
- op_code=6'b001000, rd=4'd2, mem_ready=1 -> cycle0: rd_off=0, add_pc=0; cycle1: rd_off=1, add_rd=add_imm=1, last_beat=1, add_pc=1; cycle2 back in IDLE.
- op_code=6'b001001, rd=4'd3 -> turn_off=1, mem_en=0, add_pc=1 for one cycle, no SEQ entry.
- op_code=6'b001010, rd=4'd4, mem_ready low in the cycle when rd_off=2 -> rd_off held at 2, add_pc=0; then offsets 3 and add_pc=1. Total beats 0,1,2,2,3.
- Quad sequence, flush=1 when rd_off=2 -> same cycle mem_en=0, add_pc=1; next cycle state IDLE, rd_off=0. Repeat with rst_n pulsed low mid-sequence -> immediate rd_off=0, busy=0.
- Without MULTIWORD_CU_QUAD_EN: op_code=6'b001011, rd=4'd1 -> single beat, last_beat=1, turn_off=0, add_pc=mem_ready.
